// File: rtl/kamacore_hazard_controller_pkg.sv
// Shared types and widths for the kamacore hazard controller slice.
// Provides the register-address and data widths used by the pipeline,
// the controller FSM state type and a small hazard-term helper.
package kamacore_hazard_controller_pkg;

  localparam int unsigned REG_ADDR_WIDTH   = 5;
  localparam int unsigned CPU_WIDTH        = 32;
  localparam int unsigned NUM_REGS_DEFAULT = 2 ** REG_ADDR_WIDTH;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hc_state_e;

  // One operand's contribution to the hazard term; x0 never conflicts.
  function automatic logic reg_conflict(input logic                      used,
                                        input logic [REG_ADDR_WIDTH-1:0] addr,
                                        input logic                      pend);
    return used & (addr != '0) & pend;
  endfunction

endpackage

// File: rtl/kamacore_hazard_controller_if.sv
// Decode/EX/WB sideband bundle between the pipeline and the hazard controller.
// master: pipeline side (drives ID/EX/WB info, receives sequencing controls).
// slave : controller side (receives ID/EX/WB info, drives sequencing controls,
//         FSM state and the stall-cycle counter).
interface kamacore_hazard_controller_if;
  import kamacore_hazard_controller_pkg::*;

  logic                      id_valid;
  logic [REG_ADDR_WIDTH-1:0] id_rs1_a;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_a;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic                      id_rd_we;
  logic [REG_ADDR_WIDTH-1:0] id_rd_a;
  logic                      ex_redirect;
  logic                      wb_rd_we;
  logic [REG_ADDR_WIDTH-1:0] wb_rd_a;

  logic                      stall_if;
  logic                      stall_id;
  logic                      bubble_ex;
  logic                      flush_if_id;
  logic                      issue;
  hc_state_e                 state;
  logic [CPU_WIDTH-1:0]      stall_count;

  modport master (
    output id_valid, id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
           id_rd_we, id_rd_a, ex_redirect, wb_rd_we, wb_rd_a,
    input  stall_if, stall_id, bubble_ex, flush_if_id, issue, state, stall_count
  );

  modport slave (
    input  id_valid, id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
           id_rd_we, id_rd_a, ex_redirect, wb_rd_we, wb_rd_a,
    output stall_if, stall_id, bubble_ex, flush_if_id, issue, state, stall_count
  );

endinterface

// File: rtl/kamacore_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues and cleared when its writeback commits.
// Ports: clk/rst (sync, active-high); set_en/set_a, clr_en/clr_a update
// ports; rs1_a/rs2_a/rd_a lookups return the registered pending bits.
module kamacore_scoreboard
  import kamacore_hazard_controller_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      set_en,
  input  logic [REG_ADDR_WIDTH-1:0] set_a,
  input  logic                      clr_en,
  input  logic [REG_ADDR_WIDTH-1:0] clr_a,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_a,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_a,
  input  logic [REG_ADDR_WIDTH-1:0] rd_a,
  output logic                      rs1_pend_c,
  output logic                      rs2_pend_c,
  output logic                      rd_pend_c
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear first so a same-edge set of the same register wins; x0 stays 0.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) pending_d[clr_a] = 1'b0;
    if (set_en) pending_d[set_a] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Lookups see registered state only; a same-cycle writeback does not hide a hazard.
  assign rs1_pend_c = pending_q[rs1_a];
  assign rs2_pend_c = pending_q[rs2_a];
  assign rd_pend_c  = pending_q[rd_a];

endmodule

// File: rtl/kamacore_hazard_controller.sv
// In-order pipeline sequencing controller beside the decode stage.
// Each cycle decides whether the IF/ID instruction issues, stalls on a
// RAW/WAW hazard, or is flushed after an EX redirect, and counts stall cycles.
// Ports: clk, rst (sync, active-high); hc (slave modport) carries the
// ID/EX/WB inputs, the combinational sequencing controls, the registered
// FSM state and the saturating stall counter.
module kamacore_hazard_controller
  import kamacore_hazard_controller_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned NUM_REGS     = NUM_REGS_DEFAULT
) (
  input logic                          clk,
  input logic                          rst,
  kamacore_hazard_controller_if.slave  hc
);

  localparam int unsigned FCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

  hc_state_e            state_q;
  hc_state_e            state_d;
  logic [FCNT_W-1:0]    fcnt_q;
  logic [FCNT_W-1:0]    fcnt_d;
  logic [CPU_WIDTH-1:0] stall_cnt_q;
  logic [CPU_WIDTH-1:0] stall_cnt_d;

  logic rs1_pend_c;
  logic rs2_pend_c;
  logic rd_pend_c;
  logic hazard_c;
  logic stall_c;
  logic bubble_c;
  logic flush_c;
  logic issue_c;

  kamacore_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en     (issue_c & hc.id_rd_we & (hc.id_rd_a != '0)),
    .set_a      (hc.id_rd_a),
    .clr_en     (hc.wb_rd_we),
    .clr_a      (hc.wb_rd_a),
    .rs1_a      (hc.id_rs1_a),
    .rs2_a      (hc.id_rs2_a),
    .rd_a       (hc.id_rd_a),
    .rs1_pend_c (rs1_pend_c),
    .rs2_pend_c (rs2_pend_c),
    .rd_pend_c  (rd_pend_c)
  );

  // WAW is included so at most one write per register is ever in flight.
  assign hazard_c = hc.id_valid &
                    (reg_conflict(hc.id_rs1_used, hc.id_rs1_a, rs1_pend_c) |
                     reg_conflict(hc.id_rs2_used, hc.id_rs2_a, rs2_pend_c) |
                     reg_conflict(hc.id_rd_we,    hc.id_rd_a,  rd_pend_c));

  // Sequencing decision (rst > redirect > hazard > flush window > issue) and next state.
  always_comb begin
    stall_c     = 1'b0;
    bubble_c    = 1'b1;
    flush_c     = 1'b0;
    issue_c     = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    stall_cnt_d = stall_cnt_q;

    if (rst) begin
      flush_c = 1'b1;
    end else if (hc.ex_redirect) begin
      flush_c = 1'b1;
    end else if (hazard_c) begin
      stall_c = 1'b1;
    end else if (state_q == FLUSH) begin
      flush_c = 1'b1;
    end else begin
      issue_c  = hc.id_valid;
      bubble_c = ~hc.id_valid;
    end

    // The redirect cycle itself is the first flush cycle, so FLUSH state
    // covers the remaining FLUSH_CYCLES-1 cycles.
    if (hc.ex_redirect) begin
      fcnt_d  = FCNT_LOAD;
      state_d = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end else begin
      unique case (state_q)
        RUN:   if (hazard_c)  state_d = STALL;
        STALL: if (!hazard_c) state_d = RUN;
        FLUSH: begin
          fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q <= FCNT_W'(1)) begin
            fcnt_d  = '0;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    if (stall_c && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CPU_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hc.stall_if    = stall_c;
  assign hc.stall_id    = stall_c;
  assign hc.bubble_ex   = bubble_c;
  assign hc.flush_if_id = flush_c;
  assign hc.issue       = issue_c;
  assign hc.state       = state_q;
  assign hc.stall_count = stall_cnt_q;

endmodule
